// File: rtl/bist_pkg.sv
// Shared definitions for the scan-BIST phase sequencer.
// State encoding and default chain/run dimensions.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam int DEF_SCAN_LEN   = 16;
  localparam int DEF_N_PATTERNS = 1000;

endpackage

// File: rtl/bist_cycle_counter.sv
// Up-counter with sync clear, enable and terminal flag.
// last_o is high while the count sits at MAX-1.
module bist_cycle_counter
  import bist_pkg::*;
#(
  parameter int W   = 4,
  parameter int MAX = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear beats count; no wrap, the owner clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/bist_sequencer.sv
// Scan-BIST phase sequencer: seed, shift/capture, unload, done.
// Optional ABORT port when BIST_ABORT_EN is defined.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int SCAN_LEN   = DEF_SCAN_LEN,
  parameter int N_PATTERNS = DEF_N_PATTERNS,
  localparam int SC_W = $clog2(SCAN_LEN + 1),
  localparam int PC_W = $clog2(N_PATTERNS + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  output logic            SCAN_EN,
  output logic            SEED,
  output logic            MISR_EN,
  output logic            FINISH,
  output logic            BIST_END,
  output logic            BUSY,
  output logic [PC_W-1:0] PAT_CNT
`ifdef BIST_ABORT_EN
  ,
  input  logic            ABORT
`endif
);

  state_e state_q;
  state_e state_d;

  logic scan_en_q;
  logic seed_q;
  logic misr_en_q;
  logic finish_q;
  logic bist_end_q;
  logic busy_q;

  logic            run_q;
  logic            abort;
  logic            enter_init;
  logic            sc_en;
  logic            sc_clr;
  logic            sc_last;
  logic            pc_en;
  logic            pc_clr;
  logic            pc_last;
  logic [SC_W-1:0] sc_cnt_unused;

  assign run_q = (state_q inside {S_INIT, S_SHIFT,
                                  S_CAPTURE, S_UNLOAD});

`ifdef BIST_ABORT_EN
  assign abort = ABORT & run_q;
`else
  assign abort = 1'b0;
`endif

  assign enter_init = (state_q == S_IDLE) & START;

  assign sc_en  = (state_q == S_SHIFT) |
                  (state_q == S_UNLOAD);
  assign sc_clr = enter_init | abort | (sc_en & sc_last);
  assign pc_en  = (state_q == S_CAPTURE);
  assign pc_clr = enter_init | abort;

  bist_cycle_counter #(
    .W   (SC_W),
    .MAX (SCAN_LEN)
  ) u_shift_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (sc_clr),
    .en_i   (sc_en),
    .cnt_o  (sc_cnt_unused),
    .last_o (sc_last)
  );

  bist_cycle_counter #(
    .W   (PC_W),
    .MAX (N_PATTERNS)
  ) u_pat_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (pc_clr),
    .en_i   (pc_en),
    .cnt_o  (PAT_CNT),
    .last_o (pc_last)
  );

  // Phase transitions; abort overrides any busy phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (START) state_d = S_INIT;
      S_INIT:    state_d = S_SHIFT;
      S_SHIFT:   if (sc_last) state_d = S_CAPTURE;
      S_CAPTURE: state_d = pc_last ? S_UNLOAD : S_SHIFT;
      S_UNLOAD:  if (sc_last) state_d = S_DONE;
      S_DONE:    if (!START) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // State and outputs registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      scan_en_q  <= 1'b0;
      seed_q     <= 1'b0;
      misr_en_q  <= 1'b0;
      finish_q   <= 1'b0;
      bist_end_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_en_q  <= state_d inside {S_SHIFT, S_UNLOAD};
      seed_q     <= (state_d == S_INIT);
      misr_en_q  <= state_d inside {S_SHIFT, S_CAPTURE,
                                    S_UNLOAD};
      finish_q   <= (state_d == S_DONE) &
                    (state_q != S_DONE);
      bist_end_q <= (state_d == S_DONE);
      busy_q     <= state_d inside {S_INIT, S_SHIFT,
                                    S_CAPTURE, S_UNLOAD};
    end
  end

  assign SCAN_EN  = scan_en_q;
  assign SEED     = seed_q;
  assign MISR_EN  = misr_en_q;
  assign FINISH   = finish_q;
  assign BIST_END = bist_end_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: two sizes (4x3 and 1x1)
// against a per-cycle reference schedule.
module tb_bist_sequencer;

  localparam int LA = 4;
  localparam int NA = 3;
  localparam int LB = 1;
  localparam int NB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, abort_a;
  logic rst_b, start_b, abort_b;

  logic scan_a, seed_a, misr_a, fin_a, bend_a, busy_a;
  logic scan_b, seed_b, misr_b, fin_b, bend_b, busy_b;
  logic [1:0] pat_a;
  logic [0:0] pat_b;

  int checks = 0;
  int errors = 0;

  int k[2];
  int hold[2];

  bist_sequencer #(.SCAN_LEN(LA), .N_PATTERNS(NA)) u_a (
    .CLK(clk), .RST(rst_a), .START(start_a),
    .SCAN_EN(scan_a), .SEED(seed_a), .MISR_EN(misr_a),
    .FINISH(fin_a), .BIST_END(bend_a), .BUSY(busy_a),
    .PAT_CNT(pat_a)
`ifdef BIST_ABORT_EN
    , .ABORT(abort_a)
`endif
  );

  bist_sequencer #(.SCAN_LEN(LB), .N_PATTERNS(NB)) u_b (
    .CLK(clk), .RST(rst_b), .START(start_b),
    .SCAN_EN(scan_b), .SEED(seed_b), .MISR_EN(misr_b),
    .FINISH(fin_b), .BIST_END(bend_b), .BUSY(busy_b),
    .PAT_CNT(pat_b)
`ifdef BIST_ABORT_EN
    , .ABORT(abort_b)
`endif
  );

  logic [21:0] obs_a, obs_b;
  assign obs_a = {scan_a, seed_a, misr_a, fin_a, bend_a,
                  busy_a, 16'(pat_a)};
  assign obs_b = {scan_b, seed_b, misr_b, fin_b, bend_b,
                  busy_b, 16'(pat_b)};

  // Expected outputs at offset kk from INIT entry (-1 = idle).
  function automatic logic [21:0] exp_vec(int kk, int hp,
                                          int l, int n);
    int t, j;
    logic sc, sd, ms, fi, be, bu;
    logic [15:0] p;
    t = 1 + n * (l + 1) + l;
    {sc, sd, ms, fi, be, bu} = 6'b0;
    p = 16'(hp);
    if (kk == 0) begin
      sd = 1; bu = 1; p = 0;
    end else if (kk >= 1 && kk <= n * (l + 1)) begin
      j = kk - 1;
      sc = ((j % (l + 1)) < l);
      ms = 1; bu = 1;
      p = 16'(j / (l + 1));
    end else if (kk > n * (l + 1) && kk < t) begin
      sc = 1; ms = 1; bu = 1; p = 16'(n);
    end else if (kk >= t) begin
      be = 1; fi = (kk == t); p = 16'(n);
    end
    return {sc, sd, ms, fi, be, bu, p};
  endfunction

  // Advance the reference by one clock edge.
  task automatic upd(int i, logic r, logic s, logic ab,
                     int l, int n);
    int t;
    t = 1 + n * (l + 1) + l;
    if (r) begin
      k[i] = -1; hold[i] = 0;
    end else if (ab && k[i] >= 0 && k[i] < t) begin
      k[i] = -1; hold[i] = 0;
    end else if (k[i] < 0) begin
      if (s) k[i] = 0;
    end else if (k[i] < t) begin
      k[i] = k[i] + 1;
    end else if (s) begin
      k[i] = k[i] + 1;
    end else begin
      k[i] = -1; hold[i] = n;
    end
  endtask

  task automatic chk(string tag, logic [21:0] o,
                     logic [21:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    upd(0, rst_a, start_a, abort_a, LA, NA);
    upd(1, rst_b, start_b, abort_b, LB, NB);
    @(negedge clk);
    chk("dutA", obs_a, exp_vec(k[0], hold[0], LA, NA));
    chk("dutB", obs_b, exp_vec(k[1], hold[1], LB, NB));
  endtask

  task automatic set_in(logic r, logic s, logic ab);
    rst_a = r; start_a = s; abort_a = ab;
    rst_b = r; start_b = s; abort_b = ab;
  endtask

  initial begin
    int fin_at_a, fin_at_b, fin_n;
    logic [18:0] scan_seq;
    k[0] = -1; k[1] = -1; hold[0] = 0; hold[1] = 0;
    set_in(1, 0, 0);
    tick();
    tick();
    set_in(0, 0, 0);
    tick();

    // Basic run: one-cycle START pulse.
    set_in(0, 1, 0);
    tick();
    chk("seed_a", 22'(seed_a), 22'(1));
    set_in(0, 0, 0);
    fin_at_a = -1; fin_at_b = -1; fin_n = 0;
    scan_seq = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c <= 19) scan_seq = {scan_seq[17:0], scan_a};
      if (fin_a) begin fin_at_a = c; fin_n++; end
      if (fin_b) fin_at_b = c;
      if (c == 20) begin
        chk("pat_done_a", 22'(pat_a), 22'(3));
        chk("bend_a", 22'(bend_a), 22'(1));
      end
    end
    chk("scan_seq_a", 22'(scan_seq),
        22'(19'b1111_0_1111_0_1111_0_1111));
    chk("finish_at_a", 22'(fin_at_a), 22'(20));
    chk("finish_at_b", 22'(fin_at_b), 22'(4));
    chk("finish_cnt_a", 22'(fin_n), 22'(1));
    for (int c = 0; c < 3; c++) tick();

    // Hold START through DONE for 10 cycles.
    set_in(0, 1, 0);
    fin_n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (fin_a) fin_n++;
    end
    chk("hold_fin_cnt", 22'(fin_n), 22'(1));
    chk("hold_bend", 22'(bend_a), 22'(1));
    set_in(0, 0, 0);
    tick();
    chk("idle_after_done", 22'(bend_a), 22'(0));

    // Reset during the second shift phase.
    set_in(0, 1, 0);
    tick();
    set_in(0, 0, 0);
    for (int c = 0; c < 20 && k[0] != 7; c++) tick();
    chk("at_shift2", 22'(k[0]), 22'(7));
    set_in(1, 0, 0);
    tick();
    chk("rst_pat", 22'(pat_a), 22'(0));
    chk("rst_busy", 22'(busy_a), 22'(0));
    set_in(0, 1, 0);
    tick();
    set_in(0, 0, 0);
    fin_at_a = -1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (fin_a) fin_at_a = c;
    end
    chk("rerun_finish_at", 22'(fin_at_a), 22'(20));

`ifdef BIST_ABORT_EN
    // Abort in capture of the second pattern.
    set_in(0, 1, 0);
    tick();
    set_in(0, 0, 0);
    for (int c = 0; c < 20 && k[0] != 10; c++) tick();
    chk("at_cap2", 22'(k[0]), 22'(10));
    set_in(0, 0, 1);
    tick();
    set_in(0, 0, 0);
    chk("abort_busy", 22'(busy_a), 22'(0));
    fin_n = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (fin_a || bend_a) fin_n++;
    end
    chk("abort_no_finish", 22'(fin_n), 22'(0));
`endif

    // Random START (and rare RST/ABORT) on both sizes.
    for (int c = 0; c < 800; c++) begin
      start_a = 1'($urandom_range(0, 1));
      start_b = 1'($urandom_range(0, 1));
      rst_a = ($urandom_range(0, 99) == 0);
      rst_b = ($urandom_range(0, 99) == 0);
`ifdef BIST_ABORT_EN
      abort_a = ($urandom_range(0, 39) == 0);
      abort_b = ($urandom_range(0, 39) == 0);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
